odd_seq_ctrl: RTL

//  Sequencer for the odd-sequence (x -> 2x+1) counter datapath: 0,1,3,7,...,all-ones.
//  A start command launches a burst of len_i values, streamed to a consumer over valid/ready.

---
 rtl/odd_seq_pkg.sv | 22 ++
 rtl/odd_seq_datapath.sv | 23 ++
 rtl/odd_seq_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/odd_seq_pkg.sv
// Shared definitions for the odd-sequence (x -> 2x+1) sequencer: FSM encodings and the step function.
package odd_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Operates on the low w bits of a 64-bit container so any datapath width up to 63 can share it.
    function automatic logic [63:0] next_odd(input logic [63:0] x,
                                             input logic        wrap_en,
                                             input int unsigned w);
        logic [63:0] mask;
        mask = ~({64{1'b1}} << w);
        if ((x & mask) == mask)
            next_odd = wrap_en ? 64'd0 : mask;
        else
            next_odd = ((x << 1) | 64'd1) & mask;
    endfunction

endpackage

// File: rtl/odd_seq_datapath.sv
// Odd-sequence value register: clear, load-zero and single-step controls around next_odd.
module odd_seq_datapath
    import odd_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load_zero,
    input  logic             step,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset_n || clr || load_zero)
            cnt <= '0;
        else if (step)
            cnt <= WIDTH'(next_odd(64'(cnt), wrap_en, WIDTH));
    end

endmodule

// File: rtl/odd_seq_ctrl.sv
// Burst sequencer: FSM, remaining-beat counter and valid/ready handshake around the odd-sequence datapath.
module odd_seq_ctrl
    import odd_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             wrap_en_i,
    input  logic             abort_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             sat_o,
    output logic             done_o
);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining, rem_nxt;
    logic             wrap_q, wrap_nxt;
    logic             valid_q, valid_nxt;
    logic             done_q, done_nxt;
    logic             busy_q;
    logic             clr, load_zero, step;
    logic             beat;

    assign beat = valid_q && ready_i;

    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        wrap_nxt  = wrap_q;
        valid_nxt = valid_q;
        done_nxt  = 1'b0;
        clr       = 1'b0;
        load_zero = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    wrap_nxt = wrap_en_i;
                    if (len_i != '0) begin
                        state_nxt = RUN;
                        rem_nxt   = len_i;
                        valid_nxt = 1'b1;
                        load_zero = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            RUN: begin
                // Abort takes priority; a coincident beat is still considered delivered.
                if (abort_i) begin
                    state_nxt = IDLE;
                    rem_nxt   = '0;
                    valid_nxt = 1'b0;
                    clr       = 1'b1;
                end else if (beat) begin
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = DONE;
                        rem_nxt   = '0;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        rem_nxt = remaining - LEN_W'(1);
                        step    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                clr       = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                rem_nxt   = '0;
                valid_nxt = 1'b0;
                clr       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            wrap_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            wrap_q    <= wrap_nxt;
            valid_q   <= valid_nxt;
            done_q    <= done_nxt;
            busy_q    <= (state_nxt != IDLE);
        end
    end

    odd_seq_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .load_zero(load_zero),
        .step     (step),
        .wrap_en  (wrap_nxt),
        .cnt      (cnt_o)
    );

    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign sat_o   = valid_q && (cnt_o == {WIDTH{1'b1}});

endmodule
